// File: rtl/priority_decoder_fifo_if.sv
// Handshake bundle for priority_decoder_fifo: encoded {v,b} in, one-hot y out, plus status.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
// valid never waits on ready, and in_ready depends only on registered state.
interface priority_decoder_fifo_if;
  logic [2:0] b;
  logic       v;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       clr_seen;
  logic [7:0] seen;
  logic [7:0] none_cnt;

  modport master (
    output b, v, in_valid, out_ready, clr_seen,
    input  in_ready, y, out_valid, seen, none_cnt
  );

  modport slave (
    input  b, v, in_valid, out_ready, clr_seen,
    output in_ready, y, out_valid, seen, none_cnt
  );
endinterface

// File: rtl/priority_decoder_fifo.sv
// FIFO of encoded {v,b} entries; the head is decoded to one-hot y, with sticky seen
// and a saturating count of popped "no line active" entries.
module priority_decoder_fifo #(
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  priority_decoder_fifo_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    head;
  logic          push;
  logic          pop;
  logic [7:0]    seen_r;
  logic [7:0]    none_r;

  // in_ready looks only at count, so a pop on a full FIFO does not free a slot that cycle.
  assign bus.in_ready  = (count < FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign head          = mem[rd_ptr];

  always_comb begin
    bus.y = 8'h00;
    if (bus.out_valid && !head[3]) begin
      bus.y = 8'h01 << head[2:0];
    end
  end

  assign bus.seen     = seen_r;
  assign bus.none_cnt = none_r;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {bus.v, bus.b};
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r <= 8'h00;
      none_r <= 8'h00;
    end else begin
      seen_r <= (bus.clr_seen ? 8'h00 : seen_r) | (pop ? bus.y : 8'h00);
      if (pop && head[3] && (none_r != 8'hFF)) begin
        none_r <= none_r + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_priority_decoder_fifo.sv
// Self-checking bench for priority_decoder_fifo: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_priority_decoder_fifo;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  priority_decoder_fifo_if bus ();

  priority_decoder_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] exp_q[$];
  logic [7:0] m_seen;
  logic [7:0] m_none;

  typedef struct {
    logic       in_valid;
    logic       v;
    logic [2:0] b;
    logic       out_ready;
    logic [7:0] exp_y;
    logic       exp_ov;
    logic       exp_ir;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [7:0] model_y();
    logic [3:0] h;
    if (exp_q.size() == 0) return 8'h00;
    h = exp_q[0];
    if (h[3]) return 8'h00;
    return 8'(1 << h[2:0]);
  endfunction

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_model(string tag);
    check({tag, ".y"},         bus.y,                 model_y());
    check({tag, ".out_valid"}, 8'(bus.out_valid),     8'(exp_q.size() != 0));
    check({tag, ".in_ready"},  8'(bus.in_ready),      8'(exp_q.size() < DEPTH));
    check({tag, ".seen"},      bus.seen,              m_seen);
    check({tag, ".none_cnt"},  bus.none_cnt,          m_none);
  endfunction

  // Driver: apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic iv, input logic v, input logic [2:0] b,
                      input logic ordy, input logic clr, input logic r, input string tag);
    logic       do_push;
    logic       do_pop;
    logic [7:0] py;
    bus.in_valid  = iv;
    bus.v         = v;
    bus.b         = b;
    bus.out_ready = ordy;
    bus.clr_seen  = clr;
    rst           = r;
    do_push = iv && (exp_q.size() < DEPTH);
    do_pop  = ordy && (exp_q.size() != 0);
    py      = model_y();
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      m_seen = 8'h00;
      m_none = 8'h00;
    end else begin
      m_seen = (clr ? 8'h00 : m_seen) | (do_pop ? py : 8'h00);
      if (do_pop) begin
        if (exp_q[0][3] && m_none != 8'hFF) m_none = m_none + 8'h01;
        void'(exp_q.pop_front());
      end
      if (do_push) exp_q.push_back({v, b});
    end
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_seen   = 8'h00;
    m_none   = 8'h00;

    // Reset state
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "reset0");
    step(1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, "reset1");
    check("reset.y",        bus.y,              8'h00);
    check("reset.ov",       8'(bus.out_valid),  8'h00);
    check("reset.ir",       8'(bus.in_ready),   8'h01);
    check("reset.seen",     bus.seen,           8'h00);
    check("reset.none_cnt", bus.none_cnt,       8'h00);

    // Vector table: fill to full, ignored 5th push, drain in order
    vecs[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 3'd1, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'd4, 1'b1, 8'h02, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].in_valid, vecs[i].v, vecs[i].b, vecs[i].out_ready, 1'b0, 1'b0, "vec");
      check($sformatf("vec%0d.y", i),  bus.y,             vecs[i].exp_y);
      check($sformatf("vec%0d.ov", i), 8'(bus.out_valid), 8'(vecs[i].exp_ov));
      check($sformatf("vec%0d.ir", i), 8'(bus.in_ready),  8'(vecs[i].exp_ir));
    end
    check("vec.seen", bus.seen, 8'h0F);

    // Single entry held while out_ready=0, then popped
    step(1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, "hold_push");
    check("hold.y0", bus.y, 8'h20);
    idle("hold_wait");
    idle("hold_wait");
    check("hold.y1", bus.y, 8'h20);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "hold_pop");
    check("hold.ov", 8'(bus.out_valid), 8'h00);

    // v=1 entry: y stays zero, none_cnt counts, seen unchanged
    step(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, "none_push");
    check("none.y",  bus.y,             8'h00);
    check("none.ov", 8'(bus.out_valid), 8'h01);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "none_pop");
    check("none.cnt",  bus.none_cnt, 8'h01);
    check("none.seen", bus.seen,     8'h2F);

    // Streaming at occupancy 1 across pointer wraps
    step(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, "stream_fill");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, "stream");
      check("stream.y", bus.y, 8'h80);
    end
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "stream_drain");
    check("stream.empty", 8'(bus.out_valid), 8'h00);

    // Fill seen to FF, then clear on the same edge as a pop of b=2
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 3'(i), 1'b1, 1'b0, 1'b0, "seen_fill");
    end
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "seen_last");
    check("seen.ff", bus.seen, 8'hFF);
    step(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, "clr_push");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "clr_pop");
    check("clr.seen", bus.seen, 8'h04);

    // Reset mid-burst discards contents
    step(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, "rst_q");
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "rst_q");
    step(1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, "rst_q");
    step(1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, "rst_hit");
    check("rst.ov",   8'(bus.out_valid), 8'h00);
    check("rst.ir",   8'(bus.in_ready),  8'h01);
    check("rst.seen", bus.seen,          8'h00);
    check("rst.none", bus.none_cnt,      8'h00);
    step(1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, "rst_after");
    check("rst.after_y", bus.y, 8'h40);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "rst_alone");
    check("rst.alone", 8'(bus.out_valid), 8'h00);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 79) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
